// File: rtl/mem_wb_stage.sv
// Memory/writeback pipeline stage: issues one data-memory request per load/store,
// stalls upstream until ack or timeout, and registers the writeback result.
module mem_wb_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCSrcM,
  input  logic        RegWriteM,
  input  logic        MemtoRegM,
  input  logic        MemWriteM,
  input  logic [3:0]  RdM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic        err_clr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        StallM,
  output logic        PCSrcW,
  output logic        RegWriteW,
  output logic [3:0]  RdW,
  output logic [31:0] ResultW,
  output logic [1:0]  err_status
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] cnt;

  logic memop, aligned, start, misalign, timeout, retire;
  logic in_idle, in_wait;

  always_comb begin
    in_idle  = (state == S_IDLE);
    in_wait  = (state == S_WAIT);
    memop    = MemtoRegM | MemWriteM;
    aligned  = (ALUResultM[1:0] == 2'b00);
    start    = in_idle & memop & aligned;
    misalign = in_idle & memop & ~aligned;
    // ack on the final count beats the timeout
    timeout  = in_wait & ~mem_ack & (cnt == CNT_LAST);
    StallM   = start | (in_wait & ~mem_ack & ~timeout);
    retire   = ~StallM & ~misalign & ~timeout;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      PCSrcW     <= 1'b0;
      RegWriteW  <= 1'b0;
      RdW        <= '0;
      ResultW    <= '0;
      err_status <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mem_addr  <= ALUResultM;
            mem_wdata <= WriteDataM;
            mem_we    <= MemWriteM;
            mem_req   <= 1'b1;
            cnt       <= '0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_ack || timeout) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= S_IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (retire) begin
        RegWriteW <= RegWriteM;
        PCSrcW    <= PCSrcM;
        RdW       <= RdM;
        ResultW   <= MemtoRegM ? mem_rdata : ALUResultM;
      end else begin
        RegWriteW <= 1'b0;
        PCSrcW    <= 1'b0;
      end

      // set beats clear on a per-bit basis
      err_status <= (err_status & ~{2{err_clr}}) | {timeout, misalign};
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: ALU pass-through, load/store handshakes,
// misalignment, timeout vs. late ack, and reset during an outstanding request.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCSrcM, RegWriteM, MemtoRegM, MemWriteM;
  logic [3:0]  RdM;
  logic [31:0] ALUResultM, WriteDataM;
  logic        err_clr, mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_req, mem_we, StallM, PCSrcW, RegWriteW;
  logic [31:0] mem_addr, mem_wdata, ResultW;
  logic [3:0]  RdW;
  logic [1:0]  err_status;

  int checks = 0;
  int errors = 0;
  int req_cycles;

  mem_wb_stage #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .RdM(RdM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .err_clr(err_clr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .StallM(StallM), .PCSrcW(PCSrcW), .RegWriteW(RegWriteW), .RdW(RdW),
    .ResultW(ResultW), .err_status(err_status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input logic pc, input logic rw, input logic m2r, input logic mw,
                       input logic [3:0] rd, input logic [31:0] alu, input logic [31:0] wd);
    PCSrcM = pc; RegWriteM = rw; MemtoRegM = m2r; MemWriteM = mw;
    RdM = rd; ALUResultM = alu; WriteDataM = wd;
  endtask

  task automatic nop();
    set_m(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
  endtask

  initial begin
    reset = 1'b1; err_clr = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    nop();
    #2;
    chk("rst_req",    32'(mem_req), 32'd0);
    chk("rst_regw",   32'(RegWriteW), 32'd0);
    chk("rst_result", ResultW, 32'd0);
    chk("rst_err",    32'(err_status), 32'd0);
    #5 reset = 1'b0;
    tick();

    // ALU op passes through in one cycle
    set_m(1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 32'h1234, 32'h0);
    #1 chk("alu_stall", 32'(StallM), 32'd0);
    tick();
    chk("alu_regw", 32'(RegWriteW), 32'd1);
    chk("alu_pcsrc", 32'(PCSrcW), 32'd1);
    chk("alu_rd", 32'(RdW), 32'd3);
    chk("alu_result", ResultW, 32'h1234);
    chk("alu_req", 32'(mem_req), 32'd0);
    nop();
    tick();
    chk("alu_regw_1cyc", 32'(RegWriteW), 32'd0);

    // Load, ack on third WAIT cycle
    set_m(1'b0, 1'b1, 1'b1, 1'b0, 4'd5, 32'h100, 32'h0);
    req_cycles = 0;
    #1 chk("ld_stall0", 32'(StallM), 32'd1);
    tick();
    chk("ld_addr", mem_addr, 32'h100);
    chk("ld_we", 32'(mem_we), 32'd0);
    chk("ld_regw_bubble", 32'(RegWriteW), 32'd0);
    if (mem_req) req_cycles++;
    chk("ld_stall1", 32'(StallM), 32'd1);
    tick();
    if (mem_req) req_cycles++;
    chk("ld_stall2", 32'(StallM), 32'd1);
    tick();
    if (mem_req) req_cycles++;
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    #1 chk("ld_stall3", 32'(StallM), 32'd0);
    tick();
    if (mem_req) req_cycles++;
    chk("ld_req_cycles", 32'(req_cycles), 32'd3);
    chk("ld_result", ResultW, 32'hDEADBEEF);
    chk("ld_regw", 32'(RegWriteW), 32'd1);
    chk("ld_rd", 32'(RdW), 32'd5);
    mem_ack = 1'b0; mem_rdata = '0;
    nop();
    tick();
    chk("ld_regw_1cyc", 32'(RegWriteW), 32'd0);

    // Store, ack on first WAIT cycle
    set_m(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 32'h104, 32'hCAFEF00D);
    #1 chk("st_stall0", 32'(StallM), 32'd1);
    tick();
    chk("st_req", 32'(mem_req), 32'd1);
    chk("st_we", 32'(mem_we), 32'd1);
    chk("st_wdata", mem_wdata, 32'hCAFEF00D);
    chk("st_addr", mem_addr, 32'h104);
    mem_ack = 1'b1;
    #1 chk("st_stall1", 32'(StallM), 32'd0);
    tick();
    chk("st_req_off", 32'(mem_req), 32'd0);
    chk("st_we_off", 32'(mem_we), 32'd0);
    chk("st_regw", 32'(RegWriteW), 32'd0);
    mem_ack = 1'b0;
    nop();

    // Misaligned load faults without a request
    set_m(1'b0, 1'b1, 1'b1, 1'b0, 4'd6, 32'h102, 32'h0);
    #1 chk("mis_stall", 32'(StallM), 32'd0);
    tick();
    chk("mis_req", 32'(mem_req), 32'd0);
    chk("mis_regw", 32'(RegWriteW), 32'd0);
    chk("mis_err", 32'(err_status), 32'd1);
    nop(); err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("mis_clr", 32'(err_status), 32'd0);

    // Load times out after 16 WAIT cycles
    set_m(1'b0, 1'b1, 1'b1, 1'b0, 4'd7, 32'h200, 32'h0);
    tick();
    for (int i = 1; i <= 15; i++) begin
      chk("to_req", 32'(mem_req), 32'd1);
      chk("to_stall", 32'(StallM), 32'd1);
      tick();
    end
    chk("to_req16", 32'(mem_req), 32'd1);
    chk("to_stall16", 32'(StallM), 32'd0);
    tick();
    chk("to_req_drop", 32'(mem_req), 32'd0);
    chk("to_err", 32'(err_status), 32'd2);
    chk("to_regw", 32'(RegWriteW), 32'd0);
    nop(); err_clr = 1'b1;
    #1 chk("to_idle_stall", 32'(StallM), 32'd0);
    tick();
    err_clr = 1'b0;
    chk("to_clr", 32'(err_status), 32'd0);

    // Ack on the 16th WAIT cycle completes normally
    set_m(1'b0, 1'b1, 1'b1, 1'b0, 4'd8, 32'h208, 32'h0);
    tick();
    for (int i = 1; i <= 15; i++) tick();
    mem_ack = 1'b1; mem_rdata = 32'h5A5A5A5A;
    #1 chk("late_stall", 32'(StallM), 32'd0);
    tick();
    chk("late_req", 32'(mem_req), 32'd0);
    chk("late_err", 32'(err_status), 32'd0);
    chk("late_regw", 32'(RegWriteW), 32'd1);
    chk("late_result", ResultW, 32'h5A5A5A5A);
    mem_ack = 1'b0; mem_rdata = '0;
    nop();
    tick();

    // Reset on second WAIT cycle abandons the request
    set_m(1'b0, 1'b1, 1'b1, 1'b0, 4'd9, 32'h300, 32'h0);
    tick();
    tick();
    chk("rw_req_pre", 32'(mem_req), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("rw_req", 32'(mem_req), 32'd0);
    chk("rw_regw", 32'(RegWriteW), 32'd0);
    chk("rw_rd", 32'(RdW), 32'd0);
    chk("rw_result", ResultW, 32'd0);
    chk("rw_addr", mem_addr, 32'd0);
    #1 reset = 1'b0;
    nop(); mem_ack = 1'b1; mem_rdata = 32'h11111111;
    tick();
    chk("rw_ack_req", 32'(mem_req), 32'd0);
    chk("rw_ack_regw", 32'(RegWriteW), 32'd0);
    chk("rw_ack_err", 32'(err_status), 32'd0);
    mem_ack = 1'b0;
    set_m(1'b0, 1'b1, 1'b1, 1'b0, 4'd10, 32'h300, 32'h0);
    tick();
    chk("rw_new_req", 32'(mem_req), 32'd1);
    chk("rw_new_addr", mem_addr, 32'h300);
    mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
    tick();
    chk("rw_new_result", ResultW, 32'h0BADF00D);
    chk("rw_new_regw", 32'(RegWriteW), 32'd1);
    chk("rw_new_rd", 32'(RdW), 32'd10);
    mem_ack = 1'b0;
    nop();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
